// File: rtl/zjh_mux_scan_ctrl.sv
// Scan sequencer for a 4-to-1 mux: steps Sel through all channels, waits for the
// mux output to settle, samples DateOut, and hands the assembled word off via valid/ready.
module zjh_mux_scan_ctrl #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cont,
    output logic [1:0] Sel,
    output logic       Enable,
    input  logic       DateOut,
    output logic [3:0] scan_data,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_OUTPUT = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state_r, state_s;
    logic [1:0] sel_r, sel_s;
    logic       enable_r, enable_s;
    logic [3:0] cnt_r, cnt_s;
    logic [3:0] sample_r, sample_s;
    logic [3:0] scan_data_r, scan_data_s;
    logic       valid_r, valid_s;
    logic       busy_r;

    // Next-state and next-output logic for the scan sequencer.
    always_comb begin
        state_s     = state_r;
        sel_s       = sel_r;
        enable_s    = enable_r;
        cnt_s       = cnt_r;
        sample_s    = sample_r;
        scan_data_s = scan_data_r;
        valid_s     = valid_r;
        case (state_r)
            ST_IDLE: begin
                enable_s = 1'b1;
                sel_s    = 2'd0;
                if (start) begin
                    state_s  = ST_SETTLE;
                    enable_s = 1'b0;
                    cnt_s    = 4'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                cnt_s = cnt_r + 4'd1;
                if (cnt_r == SETTLE_LAST) begin
                    state_s = ST_SAMPLE;
                end else begin
                    state_s = ST_SETTLE;
                end
            end
            ST_SAMPLE: begin
                sample_s[sel_r] = DateOut;
                if (sel_r != 2'd3) begin
                    sel_s   = sel_r + 2'd1;
                    cnt_s   = 4'd0;
                    state_s = ST_SETTLE;
                end else begin
                    // Bit 3 comes straight from DateOut; the sample register lags by a cycle.
                    scan_data_s = {DateOut, sample_r[2:0]};
                    valid_s     = 1'b1;
                    enable_s    = 1'b1;
                    sel_s       = 2'd0;
                    state_s     = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                if (valid_r && data_ready) begin
                    valid_s = 1'b0;
                    if (cont) begin
                        state_s  = ST_SETTLE;
                        sel_s    = 2'd0;
                        enable_s = 1'b0;
                        cnt_s    = 4'd0;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_OUTPUT;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                sel_s       = 2'd0;
                enable_s    = 1'b1;
                cnt_s       = 4'd0;
                sample_s    = 4'd0;
                scan_data_s = 4'd0;
                valid_s     = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            sel_r       <= 2'd0;
            enable_r    <= 1'b1;
            cnt_r       <= 4'd0;
            sample_r    <= 4'd0;
            scan_data_r <= 4'd0;
            valid_r     <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            sel_r       <= sel_s;
            enable_r    <= enable_s;
            cnt_r       <= cnt_s;
            sample_r    <= sample_s;
            scan_data_r <= scan_data_s;
            valid_r     <= valid_s;
            busy_r      <= (state_s != ST_IDLE);
        end
    end

    assign Sel        = sel_r;
    assign Enable     = enable_r;
    assign scan_data  = scan_data_r;
    assign data_valid = valid_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_zjh_mux_scan_ctrl.sv
// Directed bench for zjh_mux_scan_ctrl driving a behavioural 74HC153-style mux model.
module tb_zjh_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       cont = 1'b0;
    logic [1:0] Sel;
    logic       Enable;
    logic       DateOut;
    logic [3:0] scan_data;
    logic       data_valid;
    logic       data_ready = 1'b0;
    logic       busy;
    logic [3:0] din = 4'h0;

    int n_cmp = 0;
    int n_err = 0;

    zjh_mux_scan_ctrl #(.SETTLE_CYCLES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cont       (cont),
        .Sel        (Sel),
        .Enable     (Enable),
        .DateOut    (DateOut),
        .scan_data  (scan_data),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .busy       (busy)
    );

    assign DateOut = din[Sel] & ~Enable;

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_value({tag, "_sel"}, 4'(Sel), 4'h0);
        check_value({tag, "_en"}, 4'(Enable), 4'h1);
        check_value({tag, "_valid"}, 4'(data_valid), 4'h0);
        check_value({tag, "_busy"}, 4'(busy), 4'h0);
    endtask

    initial begin
        int vcount;
        // Reset and idle.
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check_idle("rst");
        check_value("rst_data", scan_data, 4'h0);

        // Single scan; edge 1 is the edge that samples start.
        din = 4'b1010; data_ready = 1'b1; cont = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            if (e > 1) tick();
            check_value($sformatf("scan_sel_e%0d", e), 4'(Sel), (e <= 12) ? 4'((e - 1) / 3) : 4'h0);
            check_value($sformatf("scan_en_e%0d", e), 4'(Enable), (e <= 12) ? 4'h0 : 4'h1);
            check_value($sformatf("scan_valid_e%0d", e), 4'(data_valid), (e == 13) ? 4'h1 : 4'h0);
            check_value($sformatf("scan_busy_e%0d", e), 4'(busy), (e <= 13) ? 4'h1 : 4'h0);
            if (e == 13) check_value("scan_data", scan_data, 4'hA);
        end

        // Back-pressure: consumer holds off for 20 cycles.
        din = 4'b0110; data_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (12) tick();
        check_value("bp_valid", 4'(data_valid), 4'h1);
        check_value("bp_data", scan_data, 4'h6);
        din = 4'hF;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_value($sformatf("bp_hold_valid%0d", i), 4'(data_valid), 4'h1);
            check_value($sformatf("bp_hold_data%0d", i), scan_data, 4'h6);
            check_value($sformatf("bp_hold_en%0d", i), 4'(Enable), 4'h1);
        end
        data_ready = 1'b1;
        tick();
        check_value("bp_done_valid", 4'(data_valid), 4'h0);
        check_value("bp_done_busy", 4'(busy), 4'h0);

        // Continuous mode: two back-to-back words 13 cycles apart.
        din = 4'h5; cont = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (12) tick();
        check_value("cont_valid1", 4'(data_valid), 4'h1);
        check_value("cont_data1", scan_data, 4'h5);
        din = 4'hC;
        for (int i = 1; i <= 12; i++) begin
            tick();
            check_value($sformatf("cont_gap_valid%0d", i), 4'(data_valid), 4'h0);
            check_value($sformatf("cont_gap_busy%0d", i), 4'(busy), 4'h1);
        end
        tick();
        check_value("cont_valid2", 4'(data_valid), 4'h1);
        check_value("cont_data2", scan_data, 4'hC);
        cont = 1'b0;
        tick();
        check_value("cont_end_valid", 4'(data_valid), 4'h0);
        check_value("cont_end_busy", 4'(busy), 4'h0);

        // Start pulsed again during channel 2 is ignored.
        din = 4'h9;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        check_value("ign_sel2", 4'(Sel), 4'h2);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check_value("ign_not_early", 4'(data_valid), 4'h0);
        tick();
        check_value("ign_valid", 4'(data_valid), 4'h1);
        check_value("ign_data", scan_data, 4'h9);
        vcount = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (data_valid) vcount++;
        end
        check_value("ign_one_word", 4'(vcount), 4'h0);
        check_value("ign_idle_busy", 4'(busy), 4'h0);

        // Asynchronous reset during channel-1 settle.
        din = 4'hF;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check_value("rmid_sel1", 4'(Sel), 4'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("rmid");
        check_value("rmid_data", scan_data, 4'h0);
        tick();
        rst_n = 1'b1;
        vcount = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (data_valid || busy) vcount++;
        end
        check_value("rmid_quiet", 4'(vcount), 4'h0);
        check_idle("rmid_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/zjh_mux_scan_ctrl.md
Name: zjh_mux_scan_ctrl

Overview:
- Sequencer that sits directly upstream of the zjh_74HC153 4-to-1 multiplexer.
- Drives the mux's Sel[1:0] and active-low Enable, steps through all four channels, and lets the mux output settle after each Sel change.
- Samples the returned DateOut bit for each channel and assembles the four samples into one parallel word.
- Presents that word to the consumer through a valid/ready handshake, as either a one-shot scan or a continuous scan.

Parameters:
- SETTLE_CYCLES, default 2: clock cycles Sel/Enable are held stable before DateOut is sampled; legal range 1..15.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a scan; honoured only in IDLE.
- cont  input  1  continuous mode; sampled at handshake completion.
- Sel  output  2  channel select driven to the mux.
- Enable  output  1  mux enable, active low (0 = mux passes data).
- DateOut  input  1  mux output returned to this block.
- scan_data  output  4  assembled word; bit n = sample taken with Sel = n.
- data_valid  output  1  scan_data is valid.
- data_ready  input  1  consumer accepts scan_data.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, rst_n = 0) values:
  - State = IDLE.
  - Sel = 2'b00, Enable = 1, scan_data = 4'h0.
  - data_valid = 0, busy = 0.
  - Settle counter = 0, internal sample register = 0.
  - Reset asserted mid-scan or mid-handshake aborts immediately to these values; no partial word is ever presented.
- All outputs are registered. Sel and Enable change only on clock edges.
- State machine:
  - IDLE:
    - Enable = 1, Sel = 0.
    - start = 1 -> SETTLE, with Sel = 0, Enable = 0, counter = 0.
  - SETTLE:
    - Counter increments each cycle.
    - When counter = SETTLE_CYCLES-1 -> SAMPLE.
    - Sel and Enable are held stable throughout.
  - SAMPLE (exactly 1 cycle):
    - Sample register bit [Sel] <= DateOut.
    - If Sel < 3: Sel <= Sel+1, counter <= 0, -> SETTLE.
    - If Sel = 3: scan_data <= sample register with bit 3 = DateOut, data_valid <= 1, Enable <= 1, Sel <= 0, -> OUTPUT.
  - OUTPUT:
    - data_valid = 1; scan_data is held constant until data_ready = 1.
    - On the cycle with data_valid & data_ready, transfer occurs and data_valid <= 0 at the next edge.
    - After transfer, if cont = 1: -> SETTLE with Sel = 0, Enable = 0, counter = 0 (back-to-back scan).
    - After transfer, if cont = 0: -> IDLE.
- Latency:
  - Each channel occupies SETTLE_CYCLES+1 cycles.
  - data_valid rises on the 4*(SETTLE_CYCLES+1)+1-th rising edge after the edge that samples start.
  - Default SETTLE_CYCLES = 2 gives 13 edges.
- Boundary rules:
  - start while busy is ignored and is not queued.
  - start and data_ready asserted together in OUTPUT: only the handshake matters; start is ignored.
  - data_ready held high continuously with cont = 1: one word every 4*(SETTLE_CYCLES+1)+1 cycles.
  - data_ready low indefinitely: the block stalls in OUTPUT with Enable = 1; no sampling occurs.
  - Sel never exceeds 3. The 3 -> 0 wrap happens only when leaving SAMPLE for channel 3.
  - DateOut is not sampled in SETTLE. Changes on DateOut outside a SAMPLE cycle have no effect.
  - Enable is low only during SETTLE and SAMPLE states.

Test Plan:
- Reset and idle: reset, then cycles with start = 0 -> Sel = 0, Enable = 1, data_valid = 0, busy = 0, scan_data = 0.
- Single scan with a model mux (DateIn = 4'b1010, DateOut = DateIn[Sel] & ~Enable), data_ready = 1, cont = 0:
  - data_valid is high exactly one cycle, 13 edges after start.
  - scan_data = 4'hA.
  - Sel sequence 0,1,2,3 with each value held 3 cycles.
  - Block returns to IDLE.
- Back-pressure: DateIn = 4'b0110, data_ready = 0 for 20 cycles after valid -> scan_data stays 4'h6, data_valid stays 1, Enable stays 1; asserting data_ready then completes the transfer.
- Continuous mode: cont = 1, data_ready = 1, DateIn changes from 4'h5 to 4'hC between scans -> consecutive words 4'h5 then 4'hC, spaced 13 cycles apart, with no IDLE cycle between them.
- Start ignored while busy: pulse start again during channel 2 -> the scan completes at the original 13-edge timing and only one word is produced.
- Reset mid-scan: assert rst_n = 0 during SETTLE of channel 1 -> outputs go to reset values immediately; after release, no data_valid appears until a new start.
